// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants and types for the VGA pixel fetch slice.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int HACTIVE   = 250;
  localparam int VACTIVE   = 250;
  localparam int FB_PIXELS = HACTIVE * VACTIVE;
  localparam int PIX_W     = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Replicate one 8-bit grey level onto all three colour channels.
  function automatic rgb_t gray_to_rgb(input logic [7:0] gray);
    rgb_t rgb;
    rgb.r = gray;
    rgb.g = gray;
    rgb.b = gray;
    return rgb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : Single-bit shift register of configurable depth with a
//               configurable reset value, used to align sync/blank timing
//               with framebuffer read data.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic vga_clk,
  input  logic rst_b,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_single
      // One-stage delay: plain register.
      always_ff @(posedge vga_clk or negedge rst_b) begin
        if (!rst_b) r_sr <= {DEPTH{RST_VAL}};
        else        r_sr <= din;
      end
    end else begin : g_multi
      // Multi-stage delay: shift new sample in at bit 0.
      always_ff @(posedge vga_clk or negedge rst_b) begin
        if (!rst_b) r_sr <= {DEPTH{RST_VAL}};
        else        r_sr <= {r_sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_fetch
// Description : Turns timing-generator coordinates into linear reads of a
//               double-buffered grayscale framebuffer and returns RGB plus
//               sync/blank aligned to the read data. Buffer flips happen only
//               at the first cycle of vertical blanking to avoid tearing.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_fetch #(
  parameter int HACTIVE = 250,
  parameter int VACTIVE = 250,
  parameter int ADDR_W  = 17,
  parameter int PIX_W   = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              vga_clk,
  input  logic              rst_b,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              blank_b_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              buf_sel,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              h_sync,
  output logic              v_sync,
  output logic              sync_b,
  output logic              blank_b
);

  import vga_pkg::*;

  // Register stages from coordinates to colour: one for the address, then
  // the memory latency.
  localparam int                c_depth     = 1 + MEM_LAT;
  localparam logic [ADDR_W-1:0] c_fb_pixels = ADDR_W'(HACTIVE * VACTIVE);
  localparam logic [9:0]        c_vactive   = 10'(VACTIVE);

  logic [ADDR_W-1:0] r_off;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_buf_sel;
  logic              r_swap_ack;

  logic [ADDR_W-1:0] w_base;
  logic              w_swap;
  logic              w_hs_d;
  logic              w_vs_d;
  logic              w_blank_d;
  logic [7:0]        w_gray;
  rgb_t              w_rgb;

  assign w_base = r_buf_sel ? c_fb_pixels : '0;
  // Flip only on the very first cycle of vertical blanking.
  assign w_swap = (x == 10'd0) && (y == c_vactive) && swap_req;

  // Linear offset: cleared throughout vblank, advances on visible pixels only.
  always_ff @(posedge vga_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_off <= '0;
    end else if (y >= c_vactive) begin
      r_off <= '0;
    end else if (blank_b_in) begin
      r_off <= r_off + ADDR_W'(1);
    end
  end

  // Registered read address; holds through blanking.
  always_ff @(posedge vga_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_mem_addr <= '0;
    end else if (blank_b_in) begin
      r_mem_addr <= w_base + r_off;
    end
  end

  // Buffer select toggles with a one-cycle acknowledge on each swap event.
  always_ff @(posedge vga_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_buf_sel  <= 1'b0;
      r_swap_ack <= 1'b0;
    end else begin
      r_swap_ack <= w_swap;
      if (w_swap) r_buf_sel <= ~r_buf_sel;
    end
  end

  vga_delay_line #(.DEPTH(c_depth), .RST_VAL(1'b1)) u_hs_dly (
    .vga_clk (vga_clk),
    .rst_b   (rst_b),
    .din     (h_sync_in),
    .dout    (w_hs_d)
  );

  vga_delay_line #(.DEPTH(c_depth), .RST_VAL(1'b1)) u_vs_dly (
    .vga_clk (vga_clk),
    .rst_b   (rst_b),
    .din     (v_sync_in),
    .dout    (w_vs_d)
  );

  vga_delay_line #(.DEPTH(c_depth), .RST_VAL(1'b0)) u_blank_dly (
    .vga_clk (vga_clk),
    .rst_b   (rst_b),
    .din     (blank_b_in),
    .dout    (w_blank_d)
  );

  // Fit the stored pixel into 8 bits: keep MSBs when wider, left-justify
  // and zero-fill when narrower.
  generate
    if (PIX_W >= 8) begin : g_gray_wide
      assign w_gray = mem_rdata[PIX_W-1 -: 8];
    end else begin : g_gray_narrow
      assign w_gray = {mem_rdata, {(8-PIX_W){1'b0}}};
    end
  endgenerate

  // Colour is the grey level when the aligned blank is high, black otherwise.
  always_comb begin
    w_rgb = '0;
    if (w_blank_d) w_rgb = gray_to_rgb(w_gray);
  end

  assign mem_addr = r_mem_addr;
  assign buf_sel  = r_buf_sel;
  assign swap_ack = r_swap_ack;
  assign red      = w_rgb.r;
  assign green    = w_rgb.g;
  assign blue     = w_rgb.b;
  assign h_sync   = w_hs_d;
  assign v_sync   = w_vs_d;
  assign sync_b   = w_hs_d & w_vs_d;
  assign blank_b  = w_blank_d;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pixel_fetch
// Description : Directed self-checking bench for vga_pixel_fetch with a
//               one-cycle-latency framebuffer model returning addr[7:0].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_fetch;

  localparam int ADDR_W = 17;
  localparam int PIX_W  = 8;

  logic              vga_clk = 1'b0;
  logic              rst_b   = 1'b0;
  logic [9:0]        x       = 10'd300;
  logic [9:0]        y       = 10'd300;
  logic              h_sync_in  = 1'b1;
  logic              v_sync_in  = 1'b1;
  logic              blank_b_in = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata = '0;
  logic              swap_req  = 1'b0;
  logic              swap_ack;
  logic              buf_sel;
  logic [7:0]        red, green, blue;
  logic              h_sync, v_sync, sync_b, blank_b;

  logic              force_ff = 1'b0;
  int                n_tests  = 0;
  int                n_fail   = 0;

  vga_pixel_fetch dut (
    .vga_clk    (vga_clk),
    .rst_b      (rst_b),
    .x          (x),
    .y          (y),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .blank_b_in (blank_b_in),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .buf_sel    (buf_sel),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .sync_b     (sync_b),
    .blank_b    (blank_b)
  );

  always #5 vga_clk = ~vga_clk;

  // Framebuffer model: one cycle latency, data = low byte of address.
  always @(posedge vga_clk) mem_rdata <= force_ff ? 8'hFF : mem_addr[PIX_W-1:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic drive(input int xi, input int yi, input logic bl, input logic hs, input logic vs);
    x          = 10'(xi);
    y          = 10'(yi);
    blank_b_in = bl;
    h_sync_in  = hs;
    v_sync_in  = vs;
  endtask

  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W-1:0] prev_addr;
  logic              prev_bl;
  logic              act;

  initial begin
    // ---------------- reset ----------------
    drive(300, 300, 1'b0, 1'b1, 1'b1);
    repeat (3) step();
    check("rst_addr",    32'(mem_addr), 32'd0);
    check("rst_bufsel",  32'(buf_sel),  32'd0);
    check("rst_ack",     32'(swap_ack), 32'd0);
    check("rst_red",     32'(red),      32'd0);
    check("rst_hsync",   32'(h_sync),   32'd1);
    check("rst_vsync",   32'(v_sync),   32'd1);
    check("rst_syncb",   32'(sync_b),   32'd1);
    check("rst_blank",   32'(blank_b),  32'd0);
    rst_b = 1'b1;
    step();
    step();
    check("rel_addr",    32'(mem_addr), 32'd0);
    check("rel_blank",   32'(blank_b),  32'd0);

    // ---------------- blanking / sync delay ----------------
    force_ff = 1'b1;
    drive(260, 300, 1'b0, 1'b0, 1'b1);
    step();
    check("hs_d1",       32'(h_sync),   32'd1);
    drive(260, 300, 1'b0, 1'b1, 1'b1);
    step();
    check("hs_d2",       32'(h_sync),   32'd0);
    check("syncb_d2",    32'(sync_b),   32'd0);
    check("blank_rdata", 32'(mem_rdata), 32'hFF);
    check("blank_red",   32'(red),      32'd0);
    check("blank_blue",  32'(blue),     32'd0);
    step();
    check("hs_d3",       32'(h_sync),   32'd1);
    force_ff = 1'b0;
    step();

    // ---------------- full frame, buffer 0 ----------------
    prev_bl   = 1'b0;
    prev_addr = '0;
    exp_addr  = '0;
    act       = 1'b0;
    for (int yy = 0; yy < 250; yy++) begin
      if (yy == 100) swap_req = 1'b1;
      for (int xx = 0; xx < 252; xx++) begin
        act = (xx < 250);
        drive(xx, yy, act, 1'b1, 1'b1);
        step();
        if (act) exp_addr = ADDR_W'(yy * 250 + xx);
        check("addr", 32'(mem_addr), 32'(exp_addr));
        check("red", 32'(red), prev_bl ? {24'd0, prev_addr[7:0]} : 32'd0);
        check("blank_d", 32'(blank_b), 32'(prev_bl));
        if (yy == 0 && xx == 0)     check("first_addr",  32'(mem_addr), 32'd0);
        if (yy == 0 && xx == 1)     check("first_green", 32'(green),    32'd0);
        if (yy == 1 && xx == 0)     check("line1_start", 32'(mem_addr), 32'd250);
        if (yy == 249 && xx == 249) check("last_addr",   32'(mem_addr), 32'd62499);
        if (yy == 249 && xx == 251) check("hblank_hold", 32'(mem_addr), 32'd62499);
        prev_bl   = act;
        prev_addr = exp_addr;
      end
    end
    check("no_early_swap", 32'(buf_sel), 32'd0);

    // ---------------- vblank start: swap ----------------
    drive(0, 250, 1'b0, 1'b1, 1'b0);
    step();
    check("swap_bufsel", 32'(buf_sel),  32'd1);
    check("swap_ack1",   32'(swap_ack), 32'd1);
    check("vs_d1",       32'(v_sync),   32'd1);
    swap_req = 1'b0;
    drive(1, 250, 1'b0, 1'b1, 1'b0);
    step();
    check("swap_ack0",   32'(swap_ack), 32'd0);
    check("swap_hold",   32'(buf_sel),  32'd1);
    check("vs_d2",       32'(v_sync),   32'd0);
    check("syncb_vs",    32'(sync_b),   32'd0);
    drive(2, 250, 1'b0, 1'b1, 1'b1);
    step();
    drive(0, 0, 1'b1, 1'b1, 1'b1);
    step();
    check("buf1_first",  32'(mem_addr), 32'd62500);
    check("buf1_ack",    32'(swap_ack), 32'd0);
    drive(1, 0, 1'b1, 1'b1, 1'b1);
    step();
    check("buf1_second", 32'(mem_addr), 32'd62501);
    check("buf1_red",    32'(red),      32'h24);
    check("buf1_green",  32'(green),    32'h24);
    check("buf1_blue",   32'(blue),     32'h24);
    check("buf1_blank",  32'(blank_b),  32'd1);

    // ---------------- reset mid-frame ----------------
    for (int xx = 0; xx < 5; xx++) begin
      drive(xx, 120, 1'b1, (xx < 3) ? 1'b1 : 1'b0, 1'b1);
      step();
    end
    check("pre_rst_hs",  32'(h_sync),  32'd0);
    rst_b = 1'b0;
    #1;
    check("mid_rst_addr",  32'(mem_addr), 32'd0);
    check("mid_rst_buf",   32'(buf_sel),  32'd0);
    check("mid_rst_blank", 32'(blank_b),  32'd0);
    check("mid_rst_red",   32'(red),      32'd0);
    check("mid_rst_hs",    32'(h_sync),   32'd1);
    check("mid_rst_syncb", 32'(sync_b),   32'd1);
    step();
    drive(0, 121, 1'b1, 1'b1, 1'b1);
    rst_b = 1'b1;
    step();
    check("post_rst_a0", 32'(mem_addr), 32'd0);
    drive(1, 121, 1'b1, 1'b1, 1'b1);
    step();
    check("post_rst_a1", 32'(mem_addr), 32'd1);
    drive(0, 250, 1'b0, 1'b1, 1'b0);
    step();
    check("post_rst_noswap", 32'(buf_sel), 32'd0);
    drive(0, 0, 1'b1, 1'b1, 1'b1);
    step();
    check("next_frame_addr", 32'(mem_addr), 32'd0);
    check("next_frame_buf",  32'(buf_sel),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Downstream stage of the VGA timing generator.
- Consumes its x/y coordinates and its h_sync/v_sync/blank_b timing signals, and issues linear reads to a double-buffered 8-bit grayscale framebuffer.
- Returns time-aligned RGB plus delayed sync/blank signals to the DAC pins.
- Frame-buffer swap is handshaked and takes effect only at the start of vertical blanking, so the display never tears.

Parameters:
- HACTIVE, 250, active pixels per line (matches the timing generator).
- VACTIVE, 250, active lines per frame.
- ADDR_W, 17, framebuffer address width; must hold 2*HACTIVE*VACTIVE.
- PIX_W, 8, framebuffer pixel width.
- MEM_LAT, 1, framebuffer read latency in cycles; legal values are 1 or 2.

Ports:
- vga_clk  in  1  pixel clock.
- rst_b  in  1  asynchronous active-low reset.
- x  in  10  current column from the timing generator.
- y  in  10  current line from the timing generator.
- h_sync_in  in  1  horizontal sync (active low) from the timing generator.
- v_sync_in  in  1  vertical sync (active low) from the timing generator.
- blank_b_in  in  1  high inside the visible area.
- mem_addr  out  ADDR_W  framebuffer read address (registered).
- mem_rdata  in  PIX_W  framebuffer read data, valid MEM_LAT cycles after mem_addr.
- swap_req  in  1  level request to flip the display buffer.
- swap_ack  out  1  one-cycle pulse when the flip occurs.
- buf_sel  out  1  buffer currently displayed.
- red, green, blue  out  8 each  pixel colour.
- h_sync, v_sync  out  1 each  delayed syncs.
- sync_b  out  1  h_sync & v_sync (delayed).
- blank_b  out  1  delayed blank_b_in.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - mem_addr=0, off=0, buf_sel=0, swap_ack=0.
  - red/green/blue=0.
  - h_sync=v_sync=sync_b=1 (inactive), blank_b=0.
  - All pipeline delay registers are cleared to the same inactive values.
- Offset counter off: ADDR_W bits, counts 0..HACTIVE*VACTIVE-1.
  - If y >= VACTIVE: off <= 0. This clears it every vertical blank.
  - Else if blank_b_in: off <= off+1.
  - Else: off holds. It does not reset per line, so addressing stays linear.
- Address generation:
  - When blank_b_in: mem_addr <= base + off, where base = buf_sel ? HACTIVE*VACTIVE : 0 (62500 at defaults).
  - Otherwise mem_addr holds its value.
  - Pixel (0,0) reads base+0; pixel (249,249) reads base+62499.
- Pipeline depth is D = 1 + MEM_LAT.
  - h_sync_in, v_sync_in and blank_b_in each pass through D registers.
  - Outputs are therefore aligned to mem_rdata.
- Colour output:
  - When the delayed blank is high: red=green=blue=mem_rdata. Grayscale is replicated; for PIX_W<8, left-justify and zero-fill.
  - When the delayed blank is low: colours are 0.
- sync_b is the AND of the delayed h_sync and v_sync.
- Swap handshake:
  - Swap event: the cycle where x==0, y==VACTIVE and swap_req==1.
  - On the edge ending that cycle: buf_sel <= ~buf_sel, and swap_ack <= 1 for exactly one cycle.
  - A request raised mid-frame waits for the next vblank start.
  - The requester deasserts swap_req after seeing swap_ack. If swap_req is still high at a later vblank start, another swap occurs (legal and defined).
- Simultaneous events: a swap event and the counter clear coincide. Both apply; the next frame reads the new base from off=0.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). After release, addressing resumes only after the next vblank clears off. Until then, addresses continue from 0 relative to base. This is accepted transient garbage for at most one frame.
- Out-of-range x/y (greater than the totals) are not checked; behaviour follows the rules above.

Decomposition:
- Package vga_pkg: constants HACTIVE, VACTIVE, FB_PIXELS (HACTIVE*VACTIVE), and typedefs pix_t (logic [PIX_W-1:0]) and rgb_t (struct of three 8-bit fields).
- One sub-module is natural: vga_delay_line, a parameterised-depth shift register with a reset value. It is used for the three sync/blank delays.

Test Plan:
- Reset check: hold rst_b=0 -> all outputs at the listed reset values; release -> unchanged until the first active pixel.
- First pixel: drive x=0, y=0, blank_b_in=1, with mem_rdata model returning addr[7:0] -> mem_addr=0 one cycle later; red=green=blue=0x00 and blank_b=1 D cycles after.
- Linear addressing: run a full frame -> mem_addr reaches 62499 on (249,249); line 1 starts at 250; addresses hold during hblank; after vblank, off returns to 0.
- Blanking: drive x=260 (hblank) while mem_rdata=0xFF -> colours=0, and h_sync low D cycles after h_sync_in low.
- Swap: assert swap_req at y=100 -> no change until x=0, y=250; then buf_sel=1 and swap_ack=1 for one cycle; the next frame's first address is 62500.
- Reset mid-frame: pull rst_b low at y=120 -> immediate reset values; release -> the frame after the next vblank starts at address 0 with buf_sel=0.
